// File: rtl/ct_spsram_pkg.sv
// ct_spsram_pkg: shared types and constants for the single-port SRAM
// requester controller (ct_spsram_req_ctrl) and its response FIFO.
package ct_spsram_pkg;

   // Controller states; RUN is terminal until the next reset
   typedef enum logic [1:0] {
      RESET = 2'b00,
      INIT  = 2'b01,
      RUN   = 2'b10
   } ctrl_state_e;

   // Number of read responses that can be parked while the consumer stalls
   localparam int RSP_FIFO_DEPTH = 2;

   // Width of an occupancy count able to hold 0..RSP_FIFO_DEPTH
   localparam int RSP_CNT_W = 2;

   // Occupancy value meaning "no room left"
   function automatic logic [RSP_CNT_W-1:0] rspFullCnt();
      return RSP_CNT_W'(RSP_FIFO_DEPTH);
   endfunction

endpackage

// File: rtl/ct_spsram_rsp_fifo.sv
// ct_spsram_rsp_fifo: two-entry response buffer holding SRAM read data
// that the consumer could not take in the cycle it came back.
// Push and pop may happen in the same cycle, including when full.
module ct_spsram_rsp_fifo
   import ct_spsram_pkg::*;
#(
   parameter int DATA_WIDTH = 128
)
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic [RSP_CNT_W-1:0]  cnt_o,
   output logic [DATA_WIDTH-1:0] head_o
);

   logic [DATA_WIDTH-1:0] entry_q [RSP_FIFO_DEPTH];
   logic                  wrPtr_q;
   logic                  wrPtr_d;
   logic                  rdPtr_q;
   logic                  rdPtr_d;
   logic [RSP_CNT_W-1:0]  cnt_q;
   logic [RSP_CNT_W-1:0]  cnt_d;
   logic                  doPush;
   logic                  doPop;

   // Qualify push/pop against occupancy and compute next pointers and count
   always_comb begin
      doPop   = pop_i && (cnt_q != '0);
      doPush  = push_i && ((cnt_q != rspFullCnt()) || doPop);
      wrPtr_d = wrPtr_q ^ doPush;
      rdPtr_d = rdPtr_q ^ doPop;
      cnt_d   = cnt_q;
      if (doPush && !doPop) begin
         cnt_d = cnt_q + RSP_CNT_W'(1);
      end else if (!doPush && doPop) begin
         cnt_d = cnt_q - RSP_CNT_W'(1);
      end
   end

   // Pointers and count are cleared by reset, which discards queued data
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wrPtr_q <= 1'b0;
         rdPtr_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Data storage needs no reset; only entries covered by the count are read
   always_ff @(posedge clk_i) begin
      if (doPush) begin
         entry_q[wrPtr_q] <= push_data_i;
      end
   end

   assign cnt_o  = cnt_q;
   assign head_o = entry_q[rdPtr_q];

endmodule

// File: rtl/ct_spsram_req_ctrl.sv
// ct_spsram_req_ctrl: requester-side controller for a single-port SRAM
// macro (active-low CEN/GWEN/WEN, one-cycle read latency). Turns a
// valid/ready request stream into SRAM pin activity and returns read data
// on a valid/ready response channel backed by a 2-entry buffer.
// Optional feature macro: CT_SPSRAM_INIT_EN adds a zero-fill of the whole
// array after reset before traffic is accepted.
module ct_spsram_req_ctrl
   import ct_spsram_pkg::*;
#(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 128
)
(
   input  logic                  forever_cpuclk,
   input  logic                  cpurst,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [DATA_WIDTH-1:0] req_wmask,
   output logic                  rsp_vld,
   input  logic                  rsp_rdy,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  init_done,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   ctrl_state_e           state_q;
   logic                  initDone_q;
`ifdef CT_SPSRAM_INIT_EN
   logic [ADDR_WIDTH-1:0] initCnt_q;
`endif
   logic                  rdInflight_q;
   logic                  rdInflight_d;
   logic                  runState;
   logic [RSP_CNT_W-1:0]  fifoCnt;
   logic [RSP_CNT_W-1:0]  slotsUsed;
   logic                  fifoEmpty;
   logic                  fifoPush;
   logic                  fifoPop;
   logic [DATA_WIDTH-1:0] fifoHead;
   logic                  accept;

   // Controller FSM: leaves RESET on the first edge after reset release,
   // zero-fills the array when enabled, then parks in RUN
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         state_q    <= RESET;
         initDone_q <= 1'b0;
`ifdef CT_SPSRAM_INIT_EN
         initCnt_q  <= '0;
`endif
      end else begin
         case (state_q)
            RESET: begin
`ifdef CT_SPSRAM_INIT_EN
               state_q    <= INIT;
`else
               state_q    <= RUN;
               initDone_q <= 1'b1;
`endif
            end
            INIT: begin
`ifdef CT_SPSRAM_INIT_EN
               initCnt_q <= initCnt_q + ADDR_WIDTH'(1);
               if (&initCnt_q) begin
                  state_q    <= RUN;
                  initDone_q <= 1'b1;
               end
`else
               state_q <= RESET;
`endif
            end
            RUN: begin
               state_q <= RUN;
            end
            default: begin
               state_q <= RESET;
            end
         endcase
      end
   end

   assign init_done = initDone_q;
   assign runState  = (state_q == RUN);

   // Reads are only admitted while a response slot is guaranteed free, so
   // the buffer can never overflow; writes need no slot
   always_comb begin
      slotsUsed = fifoCnt + RSP_CNT_W'(rdInflight_q);
      req_rdy   = runState && (req_wr || (slotsUsed < rspFullCnt()));
      accept    = req_vld && req_rdy;
   end

   // SRAM pins follow the accepted request combinationally; during zero-fill
   // the init counter owns the port instead
   always_comb begin
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_wen  = '1;
      sram_a    = req_addr;
      sram_d    = req_wdata;
`ifdef CT_SPSRAM_INIT_EN
      if (state_q == INIT) begin
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_wen  = '0;
         sram_a    = initCnt_q;
         sram_d    = '0;
      end else
`endif
      if (accept) begin
         sram_cen = 1'b0;
         if (req_wr) begin
            sram_gwen = 1'b0;
            sram_wen  = ~req_wmask;
         end
      end
   end

   // A read accepted this cycle has its data on sram_q next cycle
   always_comb begin
      rdInflight_d = accept && !req_wr;
   end

   // Track the read whose data is arriving from the SRAM this cycle
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         rdInflight_q <= 1'b0;
      end else begin
         rdInflight_q <= rdInflight_d;
      end
   end

   // Older buffered data goes first; returning data bypasses the buffer only
   // when nothing is queued ahead of it and the consumer takes it right away
   always_comb begin
      fifoEmpty = (fifoCnt == '0);
      fifoPop   = !fifoEmpty && rsp_rdy;
      fifoPush  = rdInflight_q && !(fifoEmpty && rsp_rdy);
      rsp_vld   = !fifoEmpty || rdInflight_q;
      rsp_rdata = fifoEmpty ? sram_q : fifoHead;
   end

   ct_spsram_rsp_fifo #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rsp_fifo (
      .clk_i       (forever_cpuclk),
      .rst_i       (cpurst),
      .push_i      (fifoPush),
      .push_data_i (sram_q),
      .pop_i       (fifoPop),
      .cnt_o       (fifoCnt),
      .head_o      (fifoHead)
   );

endmodule

// File: tb/tb_ct_spsram_req_ctrl.sv
// tb_ct_spsram_req_ctrl: table-driven bench for ct_spsram_req_ctrl with a
// behavioural SRAM and a response scoreboard. Also covers the
// CT_SPSRAM_INIT_EN zero-fill when that macro is defined.
module tb_ct_spsram_req_ctrl;

   localparam int AW    = 4;
   localparam int DW    = 16;
   localparam int DEPTH = 16;

   typedef struct {
      logic          vld;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] wmask;
      logic          rspRdy;
      logic          expRdy;
      logic          expRspVld;
   } vec_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          reqVld = 1'b0;
   logic          reqRdy;
   logic          reqWr = 1'b0;
   logic [AW-1:0] reqAddr = '0;
   logic [DW-1:0] reqWdata = '0;
   logic [DW-1:0] reqWmask = '0;
   logic          rspVld;
   logic          rspRdy = 1'b0;
   logic [DW-1:0] rspRdata;
   logic          initDone;
   logic          sramCen;
   logic          sramGwen;
   logic [DW-1:0] sramWen;
   logic [AW-1:0] sramA;
   logic [DW-1:0] sramD;
   logic [DW-1:0] sramQ = '0;

   logic [DW-1:0] sramMem [DEPTH];
   logic          memLoad = 1'b1;
   logic [DW-1:0] refMem [DEPTH];
   logic [DW-1:0] scoreboard [$];
   vec_t          vecs [$];
   int            checks = 0;
   int            errors = 0;

   always #5 clock = ~clock;

   ct_spsram_req_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .forever_cpuclk (clock),
      .cpurst         (reset),
      .req_vld        (reqVld),
      .req_rdy        (reqRdy),
      .req_wr         (reqWr),
      .req_addr       (reqAddr),
      .req_wdata      (reqWdata),
      .req_wmask      (reqWmask),
      .rsp_vld        (rspVld),
      .rsp_rdy        (rspRdy),
      .rsp_rdata      (rspRdata),
      .init_done      (initDone),
      .sram_cen       (sramCen),
      .sram_gwen      (sramGwen),
      .sram_wen       (sramWen),
      .sram_a         (sramA),
      .sram_d         (sramD),
      .sram_q         (sramQ)
   );

   // Behavioural single-port SRAM: bit-masked write, one-cycle read latency
   always @(posedge clock) begin
      if (memLoad) begin
         for (int i = 0; i < DEPTH; i++) sramMem[i] <= DW'(16'h1000 + i);
      end else if (!sramCen) begin
         if (!sramGwen) sramMem[sramA] <= (sramMem[sramA] & sramWen) | (sramD & ~sramWen);
         else           sramQ <= sramMem[sramA];
      end
   end

   // Hard stop in case the run ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic addVec(input logic vld, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] wmask,
                         input logic rspRdyIn, input logic expRdy, input logic expRspVld);
      vec_t v;
      v.vld = vld; v.wr = wr; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
      v.rspRdy = rspRdyIn; v.expRdy = expRdy; v.expRspVld = expRspVld;
      vecs.push_back(v);
   endtask

   task automatic checkOutput(input vec_t v, input string tag);
      logic          accept;
      logic [DW-1:0] expWen;
      logic [DW-1:0] expData;
      checkVal({tag, " init_done"}, 64'(initDone), 64'd1);
      checkVal({tag, " req_rdy"}, 64'(reqRdy), 64'(v.expRdy));
      checkVal({tag, " rsp_vld"}, 64'(rspVld), 64'(v.expRspVld));
      if (v.expRspVld && v.rspRdy) begin
         checks++;
         if (scoreboard.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s rsp_rdata actual=%0h expected=<no pending read>", tag, rspRdata);
         end else begin
            expData = scoreboard.pop_front();
            if (rspRdata !== expData) begin
               errors++;
               $display("[TB] FAIL %s rsp_rdata actual=%0h expected=%0h", tag, rspRdata, expData);
            end
         end
      end
      accept = v.vld && v.expRdy;
      expWen = (accept && v.wr) ? ~v.wmask : '1;
      checkVal({tag, " sram_cen"}, 64'(sramCen), 64'(!accept));
      checkVal({tag, " sram_gwen"}, 64'(sramGwen), 64'(!(accept && v.wr)));
      checkVal({tag, " sram_wen"}, 64'(sramWen), 64'(expWen));
      if (accept) begin
         checkVal({tag, " sram_a"}, 64'(sramA), 64'(v.addr));
         if (v.wr) begin
            checkVal({tag, " sram_d"}, 64'(sramD), 64'(v.wdata));
            refMem[v.addr] = (refMem[v.addr] & ~v.wmask) | (v.wdata & v.wmask);
         end else begin
            scoreboard.push_back(refMem[v.addr]);
         end
      end
   endtask

   task automatic applyStimulus(input vec_t v, input string tag);
      reqVld   = v.vld;
      reqWr    = v.wr;
      reqAddr  = v.addr;
      reqWdata = v.wdata;
      reqWmask = v.wmask;
      rspRdy   = v.rspRdy;
      @(negedge clock);
      checkOutput(v, tag);
      @(posedge clock);
      #1;
   endtask

   // Holds reset, checks reset values, releases it and walks any zero-fill;
   // returns just after the edge that enters RUN
   task automatic resetAndInit();
      reset  = 1'b1;
      reqVld = 1'b1;
      reqWr  = 1'b1;
      rspRdy = 1'b1;
      scoreboard.delete();
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkVal("rst req_rdy", 64'(reqRdy), 64'd0);
      checkVal("rst rsp_vld", 64'(rspVld), 64'd0);
      checkVal("rst init_done", 64'(initDone), 64'd0);
      checkVal("rst sram_cen", 64'(sramCen), 64'd1);
      checkVal("rst sram_gwen", 64'(sramGwen), 64'd1);
      checkVal("rst sram_wen", 64'(sramWen), 64'hFFFF);
      reset = 1'b0;
      #1;
      checkVal("rel req_rdy", 64'(reqRdy), 64'd0);
      checkVal("rel init_done", 64'(initDone), 64'd0);
      @(posedge clock);
      #1;
`ifdef CT_SPSRAM_INIT_EN
      for (int i = 0; i < DEPTH; i++) begin
         reqVld   = 1'b1;
         reqWr    = 1'b1;
         reqAddr  = AW'(DEPTH - 1 - i);
         reqWdata = 16'hFFFF;
         reqWmask = 16'hFFFF;
         @(negedge clock);
         checkVal($sformatf("init%0d init_done", i), 64'(initDone), 64'd0);
         checkVal($sformatf("init%0d req_rdy", i), 64'(reqRdy), 64'd0);
         checkVal($sformatf("init%0d rsp_vld", i), 64'(rspVld), 64'd0);
         checkVal($sformatf("init%0d pins", i),
                  {45'd0, sramCen, sramGwen, sramWen},
                  64'd0);
         checkVal($sformatf("init%0d sram_a", i), 64'(sramA), 64'(i));
         checkVal($sformatf("init%0d sram_d", i), 64'(sramD), 64'd0);
         refMem[i] = '0;
         @(posedge clock);
         #1;
      end
`endif
      reqVld = 1'b0;
   endtask

   initial begin
      vec_t v;
      $display("[TB] start");
      for (int i = 0; i < DEPTH; i++) refMem[i] = DW'(16'h1000 + i);
      @(posedge clock);
      #1;
      memLoad = 1'b0;

      // vld wr addr wdata wmask rspRdy | expRdy expRspVld
      // write-then-read, partial mask
      addVec(1, 1, 5, 16'hA5A5, 16'hFFFF, 1, 1, 0);
      addVec(1, 0, 5, 16'h0000, 16'h0000, 1, 1, 0);
      addVec(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 1);
      addVec(1, 1, 6, 16'h00FF, 16'h0F0F, 1, 1, 0);
      addVec(1, 0, 6, 16'h0000, 16'h0000, 1, 1, 0);
      addVec(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 1);
      // streaming: 8 back-to-back reads
      for (int i = 0; i < 8; i++) addVec(1, 0, AW'(i), 16'h0, 16'h0, 1, 1, (i != 0));
      addVec(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 1);
      // backpressure: reads 1,2,3 with consumer stalled, write sneaks in
      addVec(1, 0, 1, 16'h0000, 16'h0000, 0, 1, 0);
      addVec(1, 0, 2, 16'h0000, 16'h0000, 0, 1, 1);
      addVec(1, 0, 3, 16'h0000, 16'h0000, 0, 0, 1);
      addVec(1, 1, 3, 16'h3333, 16'hFFFF, 0, 1, 1);
      addVec(1, 0, 3, 16'h0000, 16'h0000, 1, 0, 1);
      addVec(1, 0, 3, 16'h0000, 16'h0000, 1, 1, 1);
      addVec(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 1);
      addVec(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0);
      // fill the buffer ahead of a mid-stream reset
      addVec(1, 0, 1, 16'h0000, 16'h0000, 0, 1, 0);
      addVec(1, 0, 2, 16'h0000, 16'h0000, 0, 1, 1);
      addVec(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);

      resetAndInit();
      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

      // mid-stream reset with two responses buffered
      reqVld  = 1'b1;
      reqWr   = 1'b0;
      reqAddr = 4'd4;
      rspRdy  = 1'b0;
      checkVal("pre-rst rsp_vld", 64'(rspVld), 64'd1);
      reset = 1'b1;
      #1;
      checkVal("midrst rsp_vld", 64'(rspVld), 64'd0);
      checkVal("midrst sram_cen", 64'(sramCen), 64'd1);
      checkVal("midrst req_rdy", 64'(reqRdy), 64'd0);
      checkVal("midrst init_done", 64'(initDone), 64'd0);
      resetAndInit();

      // read of address 9 after re-init, then a drained idle cycle
      v = '{vld:1, wr:0, addr:9, wdata:0, wmask:0, rspRdy:1, expRdy:1, expRspVld:0};
      applyStimulus(v, "post rd9");
      v = '{vld:0, wr:0, addr:0, wdata:0, wmask:0, rspRdy:1, expRdy:1, expRspVld:1};
      applyStimulus(v, "post rsp9");
      v = '{vld:0, wr:0, addr:0, wdata:0, wmask:0, rspRdy:1, expRdy:1, expRspVld:0};
      applyStimulus(v, "post idle");
      checkVal("scoreboard drained", 64'(scoreboard.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
